// File: rtl/countdown_pkg.sv
// countdown_pkg: shared state encoding, field widths and limits for the h:m:s countdown timer
package countdown_pkg;
  localparam int H_W = 5;
  localparam int M_W = 6;
  localparam int S_W = 6;
  localparam logic [M_W-1:0] MIN_MAX = 6'd59;
  localparam logic [S_W-1:0] SEC_MAX = 6'd59;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;
endpackage

// File: rtl/hms_borrow.sv
// hms_borrow: combinational h:m:s decrement with borrow; saturates at 0:0:0 instead of wrapping
module hms_borrow
  import countdown_pkg::*;
(
  input  logic [H_W-1:0] h_i,
  input  logic [M_W-1:0] m_i,
  input  logic [S_W-1:0] s_i,
  output logic [H_W-1:0] h_o,
  output logic [M_W-1:0] m_o,
  output logic [S_W-1:0] s_o,
  output logic           zero_next_o
);
  logic s_nz, m_nz, h_nz;
  assign s_nz = s_i != '0;
  assign m_nz = m_i != '0;
  assign h_nz = h_i != '0;
  assign s_o = s_nz ? s_i - 1'b1 : (m_nz || h_nz) ? SEC_MAX : '0;
  assign m_o = s_nz ? m_i : m_nz ? m_i - 1'b1 : h_nz ? MIN_MAX : '0;
  assign h_o = (s_nz || m_nz) ? h_i : h_nz ? h_i - 1'b1 : '0;
  assign zero_next_o = ~|{h_o, m_o, s_o};
endmodule

// File: rtl/countdown_hms.sv
// countdown_hms: loadable h:m:s down-counter with run/pause FSM and one-cycle expiry pulse
// Optional expiry alarm built when COUNTDOWN_ALARM_EN is defined.
module countdown_hms
  import countdown_pkg::*;
#(
  parameter int HOUR_MAX    = 23,
  parameter int ALARM_TICKS = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick,
  input  logic           load,
  input  logic [H_W-1:0] load_h,
  input  logic [M_W-1:0] load_m,
  input  logic [S_W-1:0] load_s,
  input  logic           start,
  input  logic           pause,
  input  logic           clear,
  output logic [H_W-1:0] r_hour,
  output logic [M_W-1:0] r_minute,
  output logic [S_W-1:0] r_second,
  output logic           running,
  output logic           done,
  output logic           load_err,
  output logic           alarm
);
  state_t state_q, state_d;
  logic [H_W-1:0] h_q, h_d, h_n;
  logic [M_W-1:0] m_q, m_d, m_n;
  logic [S_W-1:0] s_q, s_d, s_n;
  logic done_q, done_d, err_q, err_d, run_q, zero_n, ld_req, ld_ok;
  hms_borrow u_borrow (
    .h_i(h_q), .m_i(m_q), .s_i(s_q),
    .h_o(h_n), .m_o(m_n), .s_o(s_n),
    .zero_next_o(zero_n)
  );
  assign ld_req = load && state_q != RUN;
  assign ld_ok  = load_h <= H_W'(HOUR_MAX) && load_m <= MIN_MAX && load_s <= SEC_MAX;
  always_comb begin
    state_d = state_q;
    h_d = h_q;
    m_d = m_q;
    s_d = s_q;
    done_d = 1'b0;
    err_d = 1'b0;
    if (clear) begin
      state_d = IDLE;
      h_d = '0;
      m_d = '0;
      s_d = '0;
    end else if (ld_req) begin
      state_d = ld_ok ? IDLE : state_q;
      h_d = ld_ok ? load_h : h_q;
      m_d = ld_ok ? load_m : m_q;
      s_d = ld_ok ? load_s : s_q;
      err_d = !ld_ok;
    end else if (pause && state_q == RUN) begin
      state_d = PAUSED;
    end else if (start && (state_q == IDLE || state_q == PAUSED) && |{h_q, m_q, s_q}) begin
      state_d = RUN;
    end else if (tick && state_q == RUN) begin
      h_d = h_n;
      m_d = m_n;
      s_d = s_n;
      state_d = zero_n ? EXPIRED : RUN;
      done_d = zero_n;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      h_q <= '0;
      m_q <= '0;
      s_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      run_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q <= h_d;
      m_q <= m_d;
      s_q <= s_d;
      done_q <= done_d;
      err_q <= err_d;
      run_q <= state_d == RUN;
    end
  end
  assign r_hour   = h_q;
  assign r_minute = m_q;
  assign r_second = s_q;
  assign running  = run_q;
  assign done     = done_q;
  assign load_err = err_q;
`ifdef COUNTDOWN_ALARM_EN
  localparam int AW = $clog2(ALARM_TICKS + 1);
  logic [AW-1:0] acnt_q;
  logic alarm_q;
  // Alarm falls on the tick that exhausts the remaining count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q <= 1'b0;
      acnt_q <= '0;
    end else if (clear || ld_req) begin
      alarm_q <= 1'b0;
      acnt_q <= '0;
    end else if (done_d) begin
      alarm_q <= 1'b1;
      acnt_q <= AW'(ALARM_TICKS);
    end else if (tick && alarm_q) begin
      alarm_q <= acnt_q != AW'(1);
      acnt_q <= acnt_q - 1'b1;
    end
  end
  assign alarm = alarm_q;
`else
  assign alarm = 1'b0;
`endif
endmodule

// File: tb/tb_countdown_hms.sv
// tb_countdown_hms: directed self-checking bench for countdown_hms
module tb_countdown_hms;
  logic clk = 1'b0, rst_n = 1'b1;
  logic tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
  logic [4:0] load_h = '0;
  logic [5:0] load_m = '0, load_s = '0;
  logic [4:0] r_hour;
  logic [5:0] r_minute, r_second;
  logic running, done, load_err, alarm;
  int cmp = 0, mism = 0;

  countdown_hms #(.HOUR_MAX(23), .ALARM_TICKS(5)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .load(load),
    .load_h(load_h), .load_m(load_m), .load_s(load_s),
    .start(start), .pause(pause), .clear(clear),
    .r_hour(r_hour), .r_minute(r_minute), .r_second(r_second),
    .running(running), .done(done), .load_err(load_err), .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp++;
    assert (got === exp) else begin
      mism++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_t(input string tag, input int h, input int m, input int s);
    chk({tag, ".h"}, 32'(r_hour), h);
    chk({tag, ".m"}, 32'(r_minute), m);
    chk({tag, ".s"}, 32'(r_second), s);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int h, input int m, input int s, input logic st = 1'b0);
    load = 1'b1; start = st;
    load_h = 5'(h); load_m = 6'(m); load_s = 6'(s);
    cyc();
    load = 1'b0; start = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; cyc(); clear = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; cyc(); tick = 1'b0;
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk_t("reset", 0, 0, 0);
    chk("reset.running", 32'(running), 0);
    chk("reset.done", 32'(done), 0);
    chk("reset.load_err", 32'(load_err), 0);
    chk("reset.alarm", 32'(alarm), 0);
    @(negedge clk) rst_n = 1'b1;
    cyc();

    do_start();
    chk("start_zero.running", 32'(running), 0);

    do_load(0, 1, 0);
    chk_t("load_0100", 0, 1, 0);
    do_start();
    chk("run.running", 32'(running), 1);
    do_ticks(1);
    chk_t("tick1", 0, 0, 59);
    do_ticks(58);
    chk_t("tick59", 0, 0, 1);
    chk("tick59.done", 32'(done), 0);
    do_ticks(1);
    chk_t("tick60", 0, 0, 0);
    chk("tick60.done", 32'(done), 1);
    chk("tick60.running", 32'(running), 0);
    cyc();
    chk("done_one_cycle", 32'(done), 0);
    do_ticks(2);
    chk_t("post_expiry", 0, 0, 0);
    chk("post_expiry.done", 32'(done), 0);
    do_start();
    chk("start_expired.running", 32'(running), 0);

    do_load(2, 0, 0);
    do_start();
    do_ticks(1);
    chk_t("hour_borrow", 1, 59, 59);
    pause = 1'b1; cyc(); pause = 1'b0;
    chk("pause.running", 32'(running), 0);
    do_load(24, 0, 0);
    chk("bad_load.err", 32'(load_err), 1);
    chk_t("bad_load.keep", 1, 59, 59);
    cyc();
    chk("bad_load.err_pulse", 32'(load_err), 0);
    do_load(0, 60, 0);
    chk("bad_min.err", 32'(load_err), 1);
    chk_t("bad_min.keep", 1, 59, 59);

    do_load(0, 0, 10);
    do_start();
    pause = 1'b1; tick = 1'b1; cyc(); pause = 1'b0; tick = 1'b0;
    chk_t("pause_tick", 0, 0, 10);
    chk("pause_tick.running", 32'(running), 0);
    do_ticks(1);
    chk_t("paused_tick", 0, 0, 10);
    do_start();
    do_ticks(9);
    chk_t("resume9", 0, 0, 1);
    do_ticks(1);
    chk("resume10.done", 32'(done), 1);

    do_clear();
    chk_t("clear", 0, 0, 0);
    do_load(0, 0, 5, 1'b1);
    chk_t("load_start", 0, 0, 5);
    chk("load_start.running", 32'(running), 0);
    do_ticks(1);
    chk_t("idle_tick", 0, 0, 5);

    do_load(0, 1, 30);
    do_start();
    chk("pre_rst.running", 32'(running), 1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk_t("mid_rst", 0, 0, 0);
    chk("mid_rst.running", 32'(running), 0);
    @(negedge clk) rst_n = 1'b1;
    do_ticks(1);
    chk_t("rst_tick", 0, 0, 0);
    chk("rst_tick.running", 32'(running), 0);

    do_load(0, 0, 1);
    do_start();
    do_ticks(1);
    chk("alarm_exp.done", 32'(done), 1);
`ifdef COUNTDOWN_ALARM_EN
    chk("alarm_rise", 32'(alarm), 1);
    do_ticks(4);
    chk("alarm_tick4", 32'(alarm), 1);
    do_ticks(1);
    chk("alarm_tick5", 32'(alarm), 0);
    do_load(0, 0, 1);
    do_start();
    do_ticks(1);
    chk("alarm_rerise", 32'(alarm), 1);
    do_ticks(2);
    chk("alarm_2ticks", 32'(alarm), 1);
    do_clear();
    chk("alarm_clear", 32'(alarm), 0);
`else
    chk("alarm_off", 32'(alarm), 0);
    do_ticks(1);
    chk("alarm_off_tick", 32'(alarm), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end
endmodule
